// File: rtl/logo_pkg.sv
// Shared constants for the multi-sprite bouncing logo: sound codes, FSM encoding, colours.
// No logic; the colour helper maps a sprite index to its palette entry.
package logo_pkg;

    typedef logic [1:0] snd_code_t;

    localparam snd_code_t SND_PING = 2'b00;
    localparam snd_code_t SND_PONG = 2'b01;
    localparam snd_code_t SND_GO   = 2'b10;
    localparam snd_code_t SND_STOP = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [2:0] COL_BG = 3'b000;

    // Palette skips 0 so a sprite never renders as background.
    function automatic logic [2:0] sprite_colour(input int idx);
        return 3'((idx % 7) + 1);
    endfunction

endpackage

// File: rtl/sprite_step.sv
// One-axis position step with wall clamping and direction flip.
// Purely combinational; no backpressure.
module sprite_step #(
    parameter int VW = 3
) (
    input  logic [9:0]    pos_i,
    input  logic          dir_i,
    input  logic [VW-1:0] vel_i,
    input  logic [9:0]    limit_i,
    output logic [9:0]    pos_o,
    output logic          dir_o,
    output logic          bounce_o
);

    logic signed [10:0] nxt;

    always_comb begin
        nxt = dir_i ? ($signed({1'b0, pos_i}) - $signed(11'(vel_i)))
                    : ($signed({1'b0, pos_i}) + $signed(11'(vel_i)));
        pos_o    = pos_i;
        dir_o    = dir_i;
        bounce_o = 1'b0;
        // A stationary sprite resting on a wall must not keep re-bouncing.
        if (vel_i != '0) begin
            if (nxt <= 11'sd0) begin
                pos_o    = '0;
                dir_o    = 1'b0;
                bounce_o = 1'b1;
            end else if (nxt >= $signed({1'b0, limit_i})) begin
                pos_o    = limit_i;
                dir_o    = 1'b1;
                bounce_o = 1'b1;
            end else begin
                pos_o = nxt[9:0];
            end
        end
    end

endmodule

// File: rtl/multi_logo.sv
// N bouncing sprites: per-frame update FSM (one sprite per clock), speed control, sound events.
// Pixel colour is registered (1-cycle latency); no backpressure, frame_tick outside IDLE is dropped.
module multi_logo
    import logo_pkg::*;
#(
    parameter int N_SPRITES = 4,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPRITE_W  = 80,
    parameter int SPRITE_H  = 96,
    parameter int VEL_MAX   = 7,
    parameter int VEL_INIT  = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] x_px,
    input  logic [9:0] y_px,
    input  logic       frame_tick,
    input  logic       inc_vel,
    input  logic       dec_vel,
    output logic [2:0] color_px,
    output logic       mute,
    output logic [1:0] code_sound,
    output logic       sound_stb
);

    localparam int VW    = $clog2(VEL_MAX + 1);
    localparam int IDXW  = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam int X_LIM = SCREEN_W - SPRITE_W;
    localparam int Y_LIM = SCREEN_H - SPRITE_H;
    localparam int X_GAP = X_LIM / N_SPRITES;
    localparam int Y_GAP = Y_LIM / N_SPRITES;

    logic [1:0]          state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [VW-1:0]       vel_q, vel_d;
    logic                evt_vld_q, evt_vld_d;
    snd_code_t           evt_code_q, evt_code_d;
    logic                sound_stb_q;
    snd_code_t           code_sound_q;
    logic [2:0]          color_q, color_d;

    logic [9:0]          x_q [N_SPRITES];
    logic [9:0]          y_q [N_SPRITES];
    logic [N_SPRITES-1:0] dx_q, dy_q;

    logic [9:0]          x_nxt, y_nxt;
    logic                dx_nxt, dy_nxt;
    logic                bx, by;

    sprite_step #(.VW(VW)) u_step_x (
        .pos_i    (x_q[idx_q]),
        .dir_i    (dx_q[idx_q]),
        .vel_i    (vel_q),
        .limit_i  (10'(X_LIM)),
        .pos_o    (x_nxt),
        .dir_o    (dx_nxt),
        .bounce_o (bx)
    );

    sprite_step #(.VW(VW)) u_step_y (
        .pos_i    (y_q[idx_q]),
        .dir_i    (dy_q[idx_q]),
        .vel_i    (vel_q),
        .limit_i  (10'(Y_LIM)),
        .pos_o    (y_nxt),
        .dir_o    (dy_nxt),
        .bounce_o (by)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vel_d      = vel_q;
        evt_vld_d  = evt_vld_q;
        evt_code_d = evt_code_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d   = ST_UPDATE;
                    idx_d     = '0;
                    evt_vld_d = 1'b0;
                    if (inc_vel && !dec_vel && vel_q != VW'(VEL_MAX)) begin
                        vel_d = vel_q + VW'(1);
                    end else if (dec_vel && !inc_vel && vel_q != '0) begin
                        vel_d = vel_q - VW'(1);
                    end
                    // Speed events claim the frame's strobe before any bounce can.
                    if (vel_q == '0 && vel_d == VW'(1)) begin
                        evt_vld_d  = 1'b1;
                        evt_code_d = SND_GO;
                    end else if (vel_q == VW'(1) && vel_d == '0) begin
                        evt_vld_d  = 1'b1;
                        evt_code_d = SND_STOP;
                    end
                end
            end
            ST_UPDATE: begin
                if (!evt_vld_q && (bx || by)) begin
                    evt_vld_d  = 1'b1;
                    evt_code_d = bx ? SND_PING : SND_PONG;
                end
                if (idx_q == IDXW'(N_SPRITES - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Iterate from the top index down so the lowest covering sprite is written last.
    always_comb begin
        color_d = COL_BG;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if ({1'b0, x_px} >= {1'b0, x_q[i]} &&
                {1'b0, x_px} <  {1'b0, x_q[i]} + 11'(SPRITE_W) &&
                {1'b0, y_px} >= {1'b0, y_q[i]} &&
                {1'b0, y_px} <  {1'b0, y_q[i]} + 11'(SPRITE_H)) begin
                color_d = sprite_colour(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            vel_q        <= VW'(VEL_INIT);
            evt_vld_q    <= 1'b0;
            evt_code_q   <= SND_PING;
            sound_stb_q  <= 1'b0;
            code_sound_q <= SND_PING;
            color_q      <= COL_BG;
            for (int i = 0; i < N_SPRITES; i++) begin
                x_q[i]  <= 10'(i * X_GAP);
                y_q[i]  <= 10'(i * Y_GAP);
                dx_q[i] <= i[0];
                dy_q[i] <= i[1];
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vel_q       <= vel_d;
            evt_vld_q   <= evt_vld_d;
            evt_code_q  <= evt_code_d;
            color_q     <= color_d;
            sound_stb_q <= (state_q == ST_REPORT) && evt_vld_q;
            if (state_q == ST_REPORT && evt_vld_q) begin
                code_sound_q <= evt_code_q;
            end
            if (state_q == ST_UPDATE) begin
                x_q[idx_q]  <= x_nxt;
                y_q[idx_q]  <= y_nxt;
                dx_q[idx_q] <= dx_nxt;
                dy_q[idx_q] <= dy_nxt;
            end
        end
    end

    assign color_px   = color_q;
    assign sound_stb  = sound_stb_q;
    assign code_sound = code_sound_q;
    assign mute       = (vel_q == '0);

endmodule

// File: tb/tb_multi_logo.sv
// Randomised and directed bench for multi_logo against a frame-level reference model.
module tb_multi_logo;

    localparam int N  = 4;
    localparam int W  = 80;
    localparam int H  = 96;
    localparam int XL = 640 - W;
    localparam int YL = 480 - H;

    logic       clk = 1'b0;
    logic       clr;
    logic [9:0] x_px, y_px;
    logic       frame_tick, inc_vel, dec_vel;
    logic [2:0] color_px;
    logic       mute;
    logic [1:0] code_sound;
    logic       sound_stb;

    multi_logo dut (
        .clk        (clk),
        .clr        (clr),
        .x_px       (x_px),
        .y_px       (y_px),
        .frame_tick (frame_tick),
        .inc_vel    (inc_vel),
        .dec_vel    (dec_vel),
        .color_px   (color_px),
        .mute       (mute),
        .code_sound (code_sound),
        .sound_stb  (sound_stb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int mx [N];
    int my [N];
    int mdx[N];
    int mdy[N];
    int mvel;

    int last_n;
    int last_code;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]  = i * (XL / N);
            my[i]  = i * (YL / N);
            mdx[i] = i % 2;
            mdy[i] = (i / 2) % 2;
        end
        mvel = 1;
    endtask

    function automatic void mstep(input int p, input int d, input int v, input int lim,
                                  output int np, output int nd, output bit b);
        int n;
        np = p; nd = d; b = 1'b0;
        if (v != 0) begin
            n = (d != 0) ? p - v : p + v;
            if (n <= 0)        begin np = 0;   nd = 0; b = 1'b1; end
            else if (n >= lim) begin np = lim; nd = 1; b = 1'b1; end
            else               np = n;
        end
    endfunction

    task automatic model_tick(input bit inc, input bit dec, output bit ev, output int code);
        int pv;
        bit b;
        pv = mvel;
        if (inc && !dec)      mvel = (mvel + 1 > 7) ? 7 : mvel + 1;
        else if (dec && !inc) mvel = (mvel - 1 < 0) ? 0 : mvel - 1;
        ev = 1'b0; code = 0;
        if (pv == 0 && mvel == 1)      begin ev = 1'b1; code = 2; end
        else if (pv == 1 && mvel == 0) begin ev = 1'b1; code = 3; end
        for (int i = 0; i < N; i++) begin
            mstep(mx[i], mdx[i], mvel, XL, mx[i], mdx[i], b);
            if (b && !ev) begin ev = 1'b1; code = 0; end
            mstep(my[i], mdy[i], mvel, YL, my[i], mdy[i], b);
            if (b && !ev) begin ev = 1'b1; code = 1; end
        end
    endtask

    function automatic int model_colour(input int x, input int y);
        for (int i = 0; i < N; i++)
            if (x >= mx[i] && x < mx[i] + W && y >= my[i] && y < my[i] + H)
                return (i % 7) + 1;
        return 0;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 clr = 1'b1; frame_tick = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_color", int'(color_px), 0);
        check_eq("rst_stb", int'(sound_stb), 0);
        check_eq("rst_code", int'(code_sound), 0);
        check_eq("rst_mute", int'(mute), 0);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic do_tick(input bit inc, input bit dec);
        @(posedge clk); #1 frame_tick = 1'b1; inc_vel = inc; dec_vel = dec;
        @(posedge clk); #1 frame_tick = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0;
        last_n = 0; last_code = -1;
        repeat (N + 4) begin
            @(posedge clk); #1;
            if (sound_stb) begin last_n++; last_code = int'(code_sound); end
        end
    endtask

    task automatic tick_chk(input bit inc, input bit dec);
        bit ev;
        int ecode;
        do_tick(inc, dec);
        model_tick(inc, dec, ev, ecode);
        check_eq("stb_count", last_n, ev ? 1 : 0);
        if (ev) check_eq("stb_code", last_code, ecode);
        check_eq("mute", int'(mute), (mvel == 0) ? 1 : 0);
    endtask

    task automatic probe_exp(input int x, input int y, input int exp);
        x_px = 10'(x); y_px = 10'(y);
        @(posedge clk); #1;
        check_eq($sformatf("pixel(%0d,%0d)", x, y), int'(color_px), exp);
    endtask

    task automatic probe(input int x, input int y);
        probe_exp(x, y, model_colour(x, y));
    endtask

    task automatic check_sprites();
        for (int i = 0; i < N; i++) begin
            probe(mx[i], my[i]);
            probe(mx[i] + W - 1, my[i] + H - 1);
            if (mx[i] > 0) probe(mx[i] - 1, my[i]);
            if (my[i] > 0) probe(mx[i], my[i] - 1);
        end
    endtask

    int total, go_cnt, first_code;

    initial begin
        clr = 1'b1; x_px = '0; y_px = '0;
        frame_tick = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0;

        // Reset pixel map.
        do_reset();
        probe_exp(70, 90, 1);
        probe_exp(150, 100, 2);
        probe_exp(639, 479, 0);
        check_sprites();

        // Sprite 1 reaches the left wall after 140 frames.
        total = 0; first_code = -1;
        repeat (140) begin
            tick_chk(1'b0, 1'b0);
            total += last_n;
            if (last_n != 0 && first_code < 0) first_code = last_code;
        end
        check_eq("bounce_total", total, 1);
        check_eq("bounce_code", first_code, 0);
        probe_exp(0, 236, 2);
        check_sprites();
        tick_chk(1'b0, 1'b0);
        probe_exp(0, 237, 0);
        probe_exp(1, 237, 2);

        // Speed down to zero, then frozen frames.
        do_reset();
        tick_chk(1'b0, 1'b1);
        check_eq("stop_code", last_code, 3);
        check_eq("stop_mute", int'(mute), 1);
        total = 0;
        repeat (10) begin
            tick_chk(1'b0, 1'b0);
            total += last_n;
        end
        check_eq("frozen_stb", total, 0);
        probe_exp(70, 90, 1);
        probe_exp(150, 100, 2);
        check_sprites();

        tick_chk(1'b1, 1'b0);
        check_eq("go_code", last_code, 2);
        check_eq("go_mute", int'(mute), 0);
        tick_chk(1'b1, 1'b1);
        check_eq("both_stb", last_n, 0);
        check_sprites();

        // Saturation at VEL_MAX must not raise GO.
        do_reset();
        go_cnt = 0;
        repeat (10) begin
            tick_chk(1'b1, 1'b0);
            if (last_n != 0 && last_code == 2) go_cnt++;
        end
        check_eq("sat_go", go_cnt, 0);
        check_eq("sat_vel_model", mvel, 7);
        repeat (3) tick_chk(1'b0, 1'b0);
        check_sprites();

        // clr while the update walk is at idx 2, with a STOP pending.
        do_reset();
        @(posedge clk); #1 frame_tick = 1'b1; dec_vel = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0; dec_vel = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        total = 0;
        repeat (N + 6) begin
            @(posedge clk); #1;
            if (sound_stb) total++;
        end
        check_eq("clr_stb", total, 0);
        check_eq("clr_mute", int'(mute), 0);
        model_reset();
        check_sprites();
        tick_chk(1'b0, 1'b0);
        check_sprites();

        // Random speed requests against the model.
        do_reset();
        for (int t = 0; t < 150; t++) begin
            int r;
            r = int'($urandom_range(0, 9));
            tick_chk(r < 2 || r == 4, r == 2 || r == 3 || r == 4);
            if (t % 10 == 9) begin
                check_sprites();
                repeat (4) probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
